twiddle_rom_sdf: RTL and testbench
==================================

# twiddle_rom_sdf

Parametrised twiddle-factor generator for one radix-2 single-delay-feedback (SDF) FFT stage with butterfly span L = 2^LOG2L. It tracks each accepted input sample and tells the stage which phase the sample is in: delay-line fill, butterfly pass-through (w = 1), or twiddle multiply. In the twiddle phase it supplies W_2L^k = e^(-jπk/L) as signed fixed point. It stalls with the input stream and drains the delay line on request. One instance sits beside each butterfly stage of the FFT pipeline.

## Interface
- LOG2L, 4, log2 of butterfly span L; legal range 2..10
- WIDTH, 24, width of w_r / w_i, two's complement
- FRAC, 8, fractional bits (1.0 = 2^FRAC); requires FRAC+2 <= WIDTH
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  a sample is presented this cycle and accepted
- flush  in  1  one-cycle pulse: drain delay line after the last sample
- out_valid  out  1  w_r/w_i/state describe the sample accepted one cycle earlier
- w_r  out  WIDTH  twiddle real part
- w_i  out  WIDTH  twiddle imaginary part
- state  out  2  0 FILL, 1 PASS, 2 TWID, 3 IDLE
- busy  out  1  high in FILL/RUN/FLUSH control states

## Operation
- Control FSM: IDLE -> FILL -> RUN -> FLUSH -> IDLE.
- An advance cycle is any cycle with in_valid=1, or any cycle in FLUSH; counters move only on advance cycles. in_valid=0 outside FLUSH stalls everything.
- IDLE: counters zero. An advance enters FILL, and that sample is fill index 0.
- FILL: the first L samples of a stream get state=0, w=1+0j. The L-th sample moves the FSM to RUN.
- RUN: phase counter j runs 0..2L-1 and wraps modulo 2L, continuing across frames with no re-fill.
  - j<L: state=1, w=1+0j.
  - j>=L: state=2, k=j-L, w_r=round(cos(πk/L)·2^FRAC), w_i=-round(sin(πk/L)·2^FRAC).
  - Rounding is half-away-from-zero. Results are sign-extended to WIDTH.
- flush sampled in FILL or RUN: the FSM enters FLUSH on the next cycle. It is ignored in IDLE and FLUSH.
- FLUSH: runs exactly L self-advancing cycles with in_valid ignored. The phase counter continues and state/w follow the RUN rules; during FILL the fill counter continues the same way. After the L-th cycle the FSM returns to IDLE and all counters clear.
- in_valid and flush in the same cycle: the sample is accepted, and FLUSH begins on the next cycle.
- Width rule: 1.0 needs FRAC+1 magnitude bits plus sign, hence FRAC+2 <= WIDTH. The table holds L entries (k=0..L-1).

## Timing
- Outputs are registered, with 1-cycle latency: an advance at edge t produces out_valid=1 and that sample's state/w after edge t+1.
- Non-advance cycle: out_valid=0. w_r, w_i and state hold their last values.
- IDLE with no advance: state=3.
- Reset values (rst_n=0 at an edge): out_valid=0, w_r=2^FRAC, w_i=0, state=3, busy=0, FSM=IDLE, counters zero.
- Reset mid-stream or mid-flush aborts immediately. The first advance after reset starts a fresh FILL.
- No combinational path from inputs to outputs.

## Configuration
- TWIDDLE_QUARTER_EN defined: only L/2+1 entries are stored (k=0..L/2). For k>L/2 the block outputs w_r(k) = -w_r(L-k) and w_i(k) = w_i(L-k). Outputs must be bit-identical to the full table. Latency is unchanged.
- TWIDDLE_QUARTER_EN undefined: the full L-entry table, indexed directly by k.

## Test plan
- Reset, then 16+64 back-to-back samples (LOG2L=4, FRAC=8):
  - First 16 outputs: state=0, w=256+0j.
  - Then alternating groups of 16 with state=1, w=256+0j, and 16 with state=2.
  - At k=1: (251,-50); k=4: (181,-181); k=8: (0,-256); k=12: (-181,-181); k=15: (-251,-50).
- in_valid gaps of 1-3 cycles inside RUN:
  - out_valid low on each gap, outputs held.
  - The twiddle sequence resumes at the next k with no skip.
- flush pulsed with the last sample at j=20:
  - 16 further outputs with j=21..31 then j=0..4, in_valid ignored throughout.
  - Then state=3, busy=0; the next sample restarts FILL.
- rst_n low for one cycle at j=27: next cycle out_valid=0, state=3, w=256+0j. The following stream starts with FILL.
- LOG2L=6, WIDTH=16, FRAC=12: every k=0..63 matches the rounding formula, both with and without TWIDDLE_QUARTER_EN.
- flush during IDLE: no response, busy stays 0. flush during FLUSH: length unchanged at exactly L cycles.

Source files
------------

// File: rtl/twiddle_rom_sdf.sv
// Twiddle-factor sequencer for one radix-2 SDF FFT stage (span L = 2^LOG2L).
// Latency: 1 cycle from an accepted sample (or flush advance) to its registered outputs.
// Backpressure: none; in_valid=0 outside FLUSH freezes all counters and holds w_r/w_i/state.
//
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   in_valid        - sample accepted this cycle
//   flush           - one-cycle pulse, drains the delay line (L self-advancing cycles)
//   out_valid       - w_r/w_i/state describe the sample accepted one cycle earlier
//   w_r, w_i        - twiddle factor, signed fixed point with FRAC fractional bits
//   state           - 0 FILL, 1 PASS, 2 TWID, 3 IDLE
//   busy            - control FSM is in FILL, RUN or FLUSH
//
// Build option: define TWIDDLE_QUARTER_EN to store only k=0..L/2 and mirror the
// rest (w_r(k) = -w_r(L-k), w_i(k) = w_i(L-k)); outputs are bit-identical.
module twiddle_rom_sdf #(
    parameter int LOG2L = 4,
    parameter int WIDTH = 24,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] w_r,
    output logic [WIDTH-1:0] w_i,
    output logic [1:0]       state,
    output logic             busy
);
    localparam int L = 1 << LOG2L;
    localparam logic [LOG2L-1:0] CNT_LAST = LOG2L'(L - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(64'd1 << FRAC);
    localparam longint           PI_Q30   = 64'sd3373259426;

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_TWID = 2'd2;
    localparam logic [1:0] ST_IDLE = 2'd3;

`ifdef TWIDDLE_QUARTER_EN
    localparam int NENT = L / 2 + 1;
`else
    localparam int NENT = L;
`endif

    // Elaboration-time cos/sin(pi*k/L), rounded half-away-from-zero to FRAC bits.
    // Angles are folded into the first quadrant and evaluated by a Taylor series
    // in Q30 integer arithmetic, so no real-valued math reaches synthesis.
    function automatic longint trig_fixed(input int k, input bit want_sin);
        longint th, x2, term, acc, mag, rnd;
        int     kk, s;
        bit     neg;
        kk  = k;
        neg = 1'b0;
        s   = want_sin ? 1 : 0;
        if (2 * k > L) begin
            kk  = L - k;
            neg = !want_sin;
        end
        th   = (PI_Q30 * longint'(kk)) / longint'(L);
        x2   = (th * th) >>> 30;
        term = want_sin ? th : (64'sd1 <<< 30);
        acc  = term;
        for (int n = 1; n < 14; n++) begin
            term = -(((term * x2) >>> 30) / (longint'(2 * n - 1 + s) * longint'(2 * n + s)));
            acc  = acc + term;
        end
        mag = (acc < 0) ? -acc : acc;
        rnd = ((mag <<< FRAC) + (64'sd1 <<< 29)) >>> 30;
        if ((acc < 0) != neg) rnd = -rnd;
        return rnd;
    endfunction

    logic [WIDTH-1:0] rom_r [NENT];
    logic [WIDTH-1:0] rom_i [NENT];

    for (genvar g = 0; g < NENT; g++) begin : g_rom
        localparam logic [WIDTH-1:0] RE = WIDTH'(trig_fixed(g, 1'b0));
        localparam logic [WIDTH-1:0] IM = WIDTH'(-trig_fixed(g, 1'b1));
        assign rom_r[g] = RE;
        assign rom_i[g] = IM;
    end

    typedef enum logic [1:0] {C_IDLE, C_FILL, C_RUN, C_FLUSH} ctrl_e;

    ctrl_e            ctrl_q;
    logic [LOG2L-1:0] fcnt_q;   // fill index of the next sample
    logic             filled_q; // first L samples of the stream already seen
    logic [LOG2L:0]   j_q;      // RUN phase counter, wraps modulo 2L
    logic [LOG2L-1:0] flcnt_q;  // FLUSH cycles already spent
    logic             out_valid_q;
    logic [1:0]       state_q;
    logic [WIDTH-1:0] w_r_q;
    logic [WIDTH-1:0] w_i_q;

    logic [1:0]       state_d;
    logic [WIDTH-1:0] w_r_d;
    logic [WIDTH-1:0] w_i_d;
    logic             adv;
    logic [LOG2L-1:0] k;

    assign adv = in_valid || (ctrl_q == C_FLUSH);
    assign k   = j_q[LOG2L-1:0];

`ifdef TWIDDLE_QUARTER_EN
    localparam logic [LOG2L-1:0] HALF = LOG2L'(L / 2);
    logic [LOG2L-1:0] mir_idx;
    assign mir_idx = -k;  // L - k in LOG2L bits
`endif

    // Description of the sample advancing this cycle.
    always_comb begin
        state_d = ST_PASS;
        w_r_d   = ONE;
        w_i_d   = '0;
        if (!filled_q) begin
            state_d = ST_FILL;
        end else if (j_q[LOG2L]) begin
            state_d = ST_TWID;
`ifdef TWIDDLE_QUARTER_EN
            if (k > HALF) begin
                w_r_d = -rom_r[mir_idx];
                w_i_d = rom_i[mir_idx];
            end else begin
                w_r_d = rom_r[k];
                w_i_d = rom_i[k];
            end
`else
            w_r_d = rom_r[k];
            w_i_d = rom_i[k];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q      <= C_IDLE;
            fcnt_q      <= '0;
            filled_q    <= 1'b0;
            j_q         <= '0;
            flcnt_q     <= '0;
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
            w_r_q       <= ONE;
            w_i_q       <= '0;
        end else begin
            if (adv) begin
                out_valid_q <= 1'b1;
                state_q     <= state_d;
                w_r_q       <= w_r_d;
                w_i_q       <= w_i_d;
                if (!filled_q) begin
                    if (fcnt_q == CNT_LAST) begin
                        filled_q <= 1'b1;
                        fcnt_q   <= '0;
                    end else begin
                        fcnt_q <= fcnt_q + 1'b1;
                    end
                end else begin
                    j_q <= j_q + 1'b1;
                end
            end else begin
                out_valid_q <= 1'b0;
                if (ctrl_q == C_IDLE) state_q <= ST_IDLE;
            end

            case (ctrl_q)
                C_IDLE: begin
                    if (in_valid) ctrl_q <= C_FILL;
                end
                C_FILL: begin
                    if (flush) ctrl_q <= C_FLUSH;
                    else if (in_valid && fcnt_q == CNT_LAST) ctrl_q <= C_RUN;
                end
                C_RUN: begin
                    if (flush) ctrl_q <= C_FLUSH;
                end
                C_FLUSH: begin
                    // Last drain cycle: clearing here overrides the counter steps above.
                    if (flcnt_q == CNT_LAST) begin
                        ctrl_q   <= C_IDLE;
                        fcnt_q   <= '0;
                        filled_q <= 1'b0;
                        j_q      <= '0;
                        flcnt_q  <= '0;
                    end else begin
                        flcnt_q <= flcnt_q + 1'b1;
                    end
                end
                default: ctrl_q <= C_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign state     = state_q;
    assign w_r       = w_r_q;
    assign w_i       = w_i_q;
    assign busy      = (ctrl_q != C_IDLE);

endmodule

// File: tb/tb_twiddle_rom_sdf.sv
// Self-checking bench for twiddle_rom_sdf: instance A (L=16, WIDTH=24, FRAC=8)
// runs the stream scenarios, instance B (L=64, WIDTH=16, FRAC=12) sweeps the table.
// Expected values come from a position-based model using real cos/sin.
module tb_twiddle_rom_sdf;
    localparam int LA = 4, WA = 24, FA = 8;
    localparam int LB = 6, WB = 16, FB = 12;
    localparam int NA = 1 << LA;
    localparam int NB = 1 << LB;
    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          a_rst_n = 1'b0, a_in_valid = 1'b0, a_flush = 1'b0;
    logic          a_ov, a_busy;
    logic [1:0]    a_st;
    logic [WA-1:0] a_wr, a_wi;
    logic          b_rst_n = 1'b0, b_in_valid = 1'b0, b_flush = 1'b0;
    logic          b_ov, b_busy;
    logic [1:0]    b_st;
    logic [WB-1:0] b_wr, b_wi;

    twiddle_rom_sdf #(.LOG2L(LA), .WIDTH(WA), .FRAC(FA)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .flush(a_flush),
        .out_valid(a_ov), .w_r(a_wr), .w_i(a_wi), .state(a_st), .busy(a_busy));

    twiddle_rom_sdf #(.LOG2L(LB), .WIDTH(WB), .FRAC(FB)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .flush(b_flush),
        .out_valid(b_ov), .w_r(b_wr), .w_i(b_wi), .state(b_st), .busy(b_busy));

    int checks = 0;
    int errors = 0;
    int pa = 0;                // model: position of the next sample in A's stream
    logic [49:0] held_a;       // A's last {state, w_r, w_i}
    logic [51:0] obs_a, e_a;

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    // Sample p of a stream: first L are FILL, then phase j=(p-L) mod 2L.
    function automatic void model(input int p, input int lg, input int frac,
                                  output logic [1:0] st, output int r, output int im);
        int l, j, k;
        real a, one;
        l   = 1 << lg;
        one = real'(1 << frac);
        st  = 2'd0;
        r   = 1 << frac;
        im  = 0;
        if (p >= l) begin
            j = (p - l) % (2 * l);
            if (j < l) begin
                st = 2'd1;
            end else begin
                k  = j - l;
                a  = PI * k / l;
                st = 2'd2;
                r  = rnd($cos(a) * one);
                im = -rnd($sin(a) * one);
            end
        end
    endfunction

    function automatic logic [51:0] exp_a(input int p, input logic bsy);
        logic [1:0] st;
        int r, im;
        model(p, LA, FA, st, r, im);
        return {1'b1, bsy, st, WA'(r), WA'(im)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [35:0] obs_b, e_b;
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        repeat (2) tick();
        e_a = {1'b0, 1'b0, 2'd3, 24'd256, 24'd0};
        obs_a = {a_ov, a_busy, a_st, a_wr, a_wi};
        checks++;
        if (obs_a !== e_a) begin errors++; $display("FAIL reset_a got %h want %h", obs_a, e_a); end
        e_b = {1'b0, 1'b0, 2'd3, 16'd4096, 16'd0};
        obs_b = {b_ov, b_busy, b_st, b_wr, b_wi};
        checks++;
        if (obs_b !== e_b) begin errors++; $display("FAIL reset_b got %h want %h", obs_b, e_b); end
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        tick();
        obs_a = {a_ov, a_busy, a_st, a_wr, a_wi};
        checks++;
        if (obs_a !== e_a) begin errors++; $display("FAIL reset_idle got %h want %h", obs_a, e_a); end
        held_a = e_a[49:0];
        pa = 0;
    endtask

    task automatic test_back_to_back;
        int spot_k[5] = '{1, 4, 8, 12, 15};
        int spot_r[5] = '{251, 181, 0, -181, -251};
        int spot_i[5] = '{-50, -181, -256, -181, -50};
        int ph;
        for (int n = 0; n < 5 * NA; n++) begin
            a_in_valid = 1'b1;
            tick();
            e_a = exp_a(pa, 1'b1);
            pa++;
            obs_a = {a_ov, a_busy, a_st, a_wr, a_wi};
            checks++;
            if (obs_a !== e_a) begin errors++; $display("FAIL b2b n=%0d got %h want %h", n, obs_a, e_a); end
            held_a = e_a[49:0];
            ph = (n - NA) % (2 * NA);
            if (n >= NA && ph >= NA) begin
                for (int s = 0; s < 5; s++) begin
                    if (ph - NA == spot_k[s]) begin
                        checks++;
                        if (a_wr !== WA'(spot_r[s]) || a_wi !== WA'(spot_i[s])) begin
                            errors++;
                            $display("FAIL spot k=%0d got (%0d,%0d) want (%0d,%0d)", spot_k[s],
                                     $signed(a_wr), $signed(a_wi), spot_r[s], spot_i[s]);
                        end
                    end
                end
            end
        end
        a_in_valid = 1'b0;
    endtask

    task automatic test_gaps;
        int gap;
        for (int n = 0; n < 40; n++) begin
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
                a_in_valid = 1'b0;
                tick();
                e_a = {1'b0, 1'b1, held_a};
                obs_a = {a_ov, a_busy, a_st, a_wr, a_wi};
                checks++;
                if (obs_a !== e_a) begin errors++; $display("FAIL gap_hold n=%0d got %h want %h", n, obs_a, e_a); end
            end
            a_in_valid = 1'b1;
            tick();
            e_a = exp_a(pa, 1'b1);
            pa++;
            obs_a = {a_ov, a_busy, a_st, a_wr, a_wi};
            checks++;
            if (obs_a !== e_a) begin errors++; $display("FAIL gap_resume n=%0d got %h want %h", n, obs_a, e_a); end
            held_a = e_a[49:0];
        end
        a_in_valid = 1'b0;
    endtask

    task automatic test_flush_run;
        int guard = 0;
        // Advance until the next sample sits at j=20; it carries the flush.
        while (((pa - NA) % (2 * NA)) != 20 && guard < 64) begin
            a_in_valid = 1'b1;
            tick();
            e_a = exp_a(pa, 1'b1);
            pa++;
            obs_a = {a_ov, a_busy, a_st, a_wr, a_wi};
            checks++;
            if (obs_a !== e_a) begin errors++; $display("FAIL flush_pre got %h want %h", obs_a, e_a); end
            guard++;
        end
        a_in_valid = 1'b1; a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        e_a = exp_a(pa, 1'b1);
        pa++;
        obs_a = {a_ov, a_busy, a_st, a_wr, a_wi};
        checks++;
        if (obs_a !== e_a) begin errors++; $display("FAIL flush_last got %h want %h", obs_a, e_a); end
        for (int n = 0; n < NA; n++) begin
            a_in_valid = 1'($urandom_range(0, 1));
            tick();
            e_a = exp_a(pa, n < NA - 1);
            pa++;
            obs_a = {a_ov, a_busy, a_st, a_wr, a_wi};
            checks++;
            if (obs_a !== e_a) begin errors++; $display("FAIL flush_drain n=%0d got %h want %h", n, obs_a, e_a); end
            held_a = e_a[49:0];
        end
        a_in_valid = 1'b0;
        tick();
        e_a = {1'b0, 1'b0, 2'd3, held_a[47:0]};
        obs_a = {a_ov, a_busy, a_st, a_wr, a_wi};
        checks++;
        if (obs_a !== e_a) begin errors++; $display("FAIL flush_idle got %h want %h", obs_a, e_a); end
        pa = 0;
        a_in_valid = 1'b1;
        tick();
        e_a = exp_a(pa, 1'b1);
        pa++;
        obs_a = {a_ov, a_busy, a_st, a_wr, a_wi};
        checks++;
        if (obs_a !== e_a) begin errors++; $display("FAIL flush_refill got %h want %h", obs_a, e_a); end
    endtask

    task automatic test_reset_midstream;
        while (pa < NA + 27) begin
            a_in_valid = 1'b1;
            tick();
            e_a = exp_a(pa, 1'b1);
            pa++;
            obs_a = {a_ov, a_busy, a_st, a_wr, a_wi};
            checks++;
            if (obs_a !== e_a) begin errors++; $display("FAIL rst_pre got %h want %h", obs_a, e_a); end
        end
        a_rst_n = 1'b0; a_in_valid = 1'b1;
        tick();
        a_rst_n = 1'b1; a_in_valid = 1'b0;
        e_a = {1'b0, 1'b0, 2'd3, 24'd256, 24'd0};
        obs_a = {a_ov, a_busy, a_st, a_wr, a_wi};
        checks++;
        if (obs_a !== e_a) begin errors++; $display("FAIL rst_mid got %h want %h", obs_a, e_a); end
        tick();
        obs_a = {a_ov, a_busy, a_st, a_wr, a_wi};
        checks++;
        if (obs_a !== e_a) begin errors++; $display("FAIL rst_mid_idle got %h want %h", obs_a, e_a); end
        pa = 0;
        for (int n = 0; n < NA + 2; n++) begin
            a_in_valid = 1'b1;
            tick();
            e_a = exp_a(pa, 1'b1);
            pa++;
            obs_a = {a_ov, a_busy, a_st, a_wr, a_wi};
            checks++;
            if (obs_a !== e_a) begin errors++; $display("FAIL rst_restart n=%0d got %h want %h", n, obs_a, e_a); end
            held_a = e_a[49:0];
        end
        a_in_valid = 1'b0;
    endtask

    task automatic test_flush_during_flush;
        int ns;
        ns = $urandom_range(1, 8);
        for (int n = 0; n < ns; n++) begin
            a_in_valid = 1'b1;
            tick();
            e_a = exp_a(pa, 1'b1);
            pa++;
            obs_a = {a_ov, a_busy, a_st, a_wr, a_wi};
            checks++;
            if (obs_a !== e_a) begin errors++; $display("FAIL ffl_pre got %h want %h", obs_a, e_a); end
            held_a = e_a[49:0];
        end
        // Flush alone in RUN: no sample this cycle, drain starts next cycle.
        a_in_valid = 1'b0; a_flush = 1'b1;
        tick();
        e_a = {1'b0, 1'b1, held_a};
        obs_a = {a_ov, a_busy, a_st, a_wr, a_wi};
        checks++;
        if (obs_a !== e_a) begin errors++; $display("FAIL ffl_enter got %h want %h", obs_a, e_a); end
        for (int n = 0; n < NA + 4; n++) begin
            a_flush = 1'($urandom_range(0, 1));
            a_in_valid = (n < NA) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            if (n < NA) begin
                e_a = exp_a(pa, n < NA - 1);
                pa++;
            end else begin
                e_a = {1'b0, 1'b0, 2'd3, held_a[47:0]};
            end
            held_a = e_a[49:0];
            obs_a = {a_ov, a_busy, a_st, a_wr, a_wi};
            checks++;
            if (obs_a !== e_a) begin errors++; $display("FAIL ffl_len n=%0d got %h want %h", n, obs_a, e_a); end
        end
        a_flush = 1'b0;
    endtask

    task automatic test_idle_flush;
        for (int n = 0; n < 4; n++) begin
            a_in_valid = 1'b0;
            a_flush = 1'(n % 2 == 0);
            tick();
            e_a = {1'b0, 1'b0, 2'd3, held_a[47:0]};
            obs_a = {a_ov, a_busy, a_st, a_wr, a_wi};
            checks++;
            if (obs_a !== e_a) begin errors++; $display("FAIL idle_flush n=%0d got %h want %h", n, obs_a, e_a); end
        end
        a_flush = 1'b0;
    endtask

    task automatic test_flush_in_fill;
        int nf;
        nf = $urandom_range(1, 10);
        pa = 0;
        for (int n = 0; n < nf; n++) begin
            a_in_valid = 1'b1;
            a_flush = 1'(n == nf - 1);
            tick();
            e_a = exp_a(pa, 1'b1);
            pa++;
            obs_a = {a_ov, a_busy, a_st, a_wr, a_wi};
            checks++;
            if (obs_a !== e_a) begin errors++; $display("FAIL fill_flush_pre n=%0d got %h want %h", n, obs_a, e_a); end
        end
        a_flush = 1'b0;
        for (int n = 0; n < NA + 1; n++) begin
            a_in_valid = (n < NA) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            if (n < NA) begin
                e_a = exp_a(pa, n < NA - 1);
                pa++;
            end else begin
                e_a = {1'b0, 1'b0, 2'd3, held_a[47:0]};
            end
            held_a = e_a[49:0];
            obs_a = {a_ov, a_busy, a_st, a_wr, a_wi};
            checks++;
            if (obs_a !== e_a) begin errors++; $display("FAIL fill_flush n=%0d got %h want %h", n, obs_a, e_a); end
        end
    endtask

    task automatic test_wide_table;
        logic [1:0]  st;
        int          r, im;
        logic [35:0] obs_b, e_b;
        for (int n = 0; n < 3 * NB; n++) begin
            b_in_valid = 1'b1;
            tick();
            model(n, LB, FB, st, r, im);
            e_b = {1'b1, 1'b1, st, WB'(r), WB'(im)};
            obs_b = {b_ov, b_busy, b_st, b_wr, b_wi};
            checks++;
            if (obs_b !== e_b) begin errors++; $display("FAIL wide n=%0d got %h want %h", n, obs_b, e_b); end
        end
        b_in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_flush_run();
        test_reset_midstream();
        test_flush_during_flush();
        test_idle_flush();
        test_flush_in_fill();
        test_wide_table();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
